// File: rtl/dmem_latency_responder.sv
// Data-memory responder: word-wide little-endian SRAM that completes one request at a time
// after a fixed LATENCY, signalling completion with a registered done/err pulse.
`default_nettype none

module dmem_latency_responder #(
  parameter int SIZE_POW2 = 12,
  parameter int LATENCY   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_done_o,
  output logic        dmem_err_o,
  output logic        busy_o
);

  localparam int         IDX_W    = SIZE_POW2 - 2;
  localparam int         WORDS    = 2 ** IDX_W;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         cnt;
  logic               op_write;
  logic               op_err;
  logic [IDX_W-1:0]   op_idx;
  logic [31:0]        op_data;
  logic [31:0]        mem [WORDS];

  logic               req;
  logic               req_err;
  logic               accept;
  logic               commit;
  logic [IDX_W-1:0]   commit_idx;
  logic [31:0]        commit_data;
  logic               unused_addr_hi;

  assign req            = dmem_read_i | dmem_write_i;
  assign req_err        = (dmem_addr_i[1:0] != 2'b00) | (dmem_read_i & dmem_write_i);
  assign accept         = (state == IDLE) & req;
  assign unused_addr_hi = ^dmem_addr_i[31:SIZE_POW2];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (LATENCY == 1) ? DONE : WAIT;
      WAIT: begin
        if (!req)               state_nxt = IDLE;
        else if (cnt == 8'd1)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the write lands on the accept edge, so it must come straight from the inputs.
  always_comb begin
    commit_idx  = op_idx;
    commit_data = op_data;
    commit      = op_write & ~op_err;
    if (state == IDLE) begin
      commit_idx  = dmem_addr_i[SIZE_POW2-1:2];
      commit_data = dmem_data_i;
      commit      = dmem_write_i & ~req_err;
    end
    commit = commit & (state_nxt == DONE) & (state != DONE) & reset_i;
  end

  always_ff @(posedge clk_i) begin
    if (commit) mem[commit_idx] <= commit_data;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt            <= 8'd0;
      op_write       <= 1'b0;
      op_err         <= 1'b0;
      op_idx         <= '0;
      op_data        <= 32'd0;
      dmem_rd_data_o <= 32'd0;
      dmem_done_o    <= 1'b0;
      dmem_err_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= CNT_INIT;
        op_write <= dmem_write_i;
        op_err   <= req_err;
        op_idx   <= dmem_addr_i[SIZE_POW2-1:2];
        op_data  <= dmem_data_i;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end else begin
        cnt <= 8'd0;
      end
      // The pulse trails the DONE state by one edge so every output stays registered.
      dmem_done_o    <= (state == DONE);
      dmem_err_o     <= (state == DONE) & op_err;
      dmem_rd_data_o <= ((state == DONE) & ~op_write & ~op_err) ? mem[op_idx] : 32'd0;
      busy_o         <= (state_nxt != IDLE);
    end
  end

endmodule

`default_nettype wire
